eth_udp_packetizer: RTL and testbench
=====================================

# eth_udp_packetizer

Upstream feeder for the direct-PHY UDP transmitter. It buffers a byte stream from the capture logic and groups it into UDP payloads of fixed length. For each payload it raises the transmitter's start request, supplies the payload length, and hands over one byte per read strobe. Partially filled buffers are flushed as short frames, padded to the Ethernet minimum, after an inactivity timeout or an explicit flush.

## Interface
Parameters:
- DEPTH, 2048: buffer size in bytes; power of two.
- PKT_LEN, 1024: full payload length in bytes; MIN_LEN ≤ PKT_LEN ≤ DEPTH.
- MIN_LEN, 18: minimum UDP payload. Gives a 46-byte minimum Ethernet payload.
- TIMEOUT, 65535: idle cycles before a partial flush; ≥1.

Ports:
- clk  in  1  single clock, driven from the transmitter's user clock output.
- reset_i  in  1  synchronous, active-high reset.
- in_data_i  in  8  capture byte.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  buffer can accept a byte.
- flush_i  in  1  single-cycle request to send pending bytes now.
- usr_start_o  out  1  frame request to the transmitter.
- usr_data_len_o  out  16  UDP payload length of the current frame.
- usr_datard_i  in  1  transmitter consumed the byte on usr_data_o.
- usr_data_o  out  8  current payload byte.
- pkt_count_o  out  16  frames issued; wraps modulo 2^16.
- overflow_o  out  1  sticky: a byte was offered while the buffer was full.

## Operation
- Write side: a byte is accepted on any cycle with in_valid_i & in_ready_o. in_ready_o = ~full.
- States:
  - IDLE: accumulating.
    - count ≥ PKT_LEN → START, latching len = PKT_LEN and real = PKT_LEN.
    - Otherwise, if count > 0 and (timer == TIMEOUT or flush_i) → START, latching real = count and len = max(count, MIN_LEN).
    - Full-packet check has priority over flush and timeout.
  - START: usr_start_o = 1. On the first usr_datard_i pulse: usr_start_o drops, that byte is consumed, go to SEND.
  - SEND: each usr_datard_i consumes one payload byte. After len bytes are consumed → IDLE, and pkt_count_o increments.
- Read side:
  - Payload byte i < real is popped from the buffer.
  - Payload byte i ≥ real is a pad byte: usr_data_o = 8'h00, and nothing is popped.
- Timer:
  - Clears on every accepted write, and whenever count == 0 or state ≠ IDLE.
  - Otherwise increments each cycle in IDLE, saturating at TIMEOUT.
- flush_i with count == 0 is ignored. flush_i outside IDLE is ignored and not remembered.
- Writes continue in every state. A simultaneous write and pop leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits; full when count == DEPTH.
- overflow_o: set on in_valid_i & ~in_ready_o, cleared only by reset. The offered byte is dropped.
- usr_data_len_o holds the latched len from START entry through the end of SEND. In IDLE it shows PKT_LEN.

## Timing
- Reset values, as seen on the edge where reset_i is sampled high:
  - state IDLE, pointers 0, count 0, timer 0.
  - usr_start_o 0, usr_data_o 8'h00, pkt_count_o 0, overflow_o 0.
  - in_ready_o 0 while reset_i is high; 1 from the first cycle after release.
- Reset mid-frame discards the frame and all buffered bytes. Start is deasserted by the next edge.
- usr_start_o is registered and asserts one cycle after the IDLE→START decision.
- Byte delivery:
  - usr_data_o shows the current byte from START entry.
  - After the edge that samples usr_datard_i high, the next byte is valid on usr_data_o within 1 cycle.
  - Consecutive usr_datard_i pulses must be ≥2 cycles apart; the transmitter reads one byte per two clocks.
- After the last byte, IDLE is entered on the next edge. A new START can follow after one IDLE cycle.

## Structure
- Package eth_pkt_pkg holds:
  - the state encoding (IDLE, START, SEND);
  - ETH_MIN_PAYLOAD = 46, IP_HDR_LEN = 20, UDP_HDR_LEN = 8;
  - the derived MIN_LEN default.
- Sub-module eth_byte_fifo: synchronous dual-port RAM FIFO with pointers, count, full and empty, and a registered read port. Inferred block RAM.
- The top level contains only the FSM, length latch, pad counter, timer and statistics.

## Test plan
- PKT_LEN=32: write 32 bytes 0x00..0x1F, pulse datard every 2 cycles → start asserts, len = 32, data 0x00..0x1F, pkt_count_o = 1.
- TIMEOUT=100: write 5 bytes then idle → start 101 cycles after the last write, len = 18, data = 5 bytes then 13 × 0x00.
- flush_i with 20 bytes buffered → len = 20, no pad, count returns to 0.
- DEPTH=64: write 70 bytes with no reads → in_ready_o drops at 64, overflow_o = 1, the first 64 bytes are intact on readout.
- Continuous writes during SEND, one byte every 2 cycles → next frame starts with no lost or duplicated bytes across the boundary.
- reset_i mid-SEND → usr_start_o = 0, count = 0, pkt_count_o = 0 on the next cycle; a fresh frame then works.

Source files
------------

// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared state encoding and Ethernet/IP/UDP size constants for the UDP packetizer
package eth_pkt_pkg;
    typedef enum logic [1:0] {IDLE, START, SEND} state_t;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int IP_HDR_LEN      = 20;
    localparam int UDP_HDR_LEN     = 8;
    // Smallest UDP payload that still fills the minimum Ethernet payload.
    localparam int MIN_UDP_LEN     = ETH_MIN_PAYLOAD - IP_HDR_LEN - UDP_HDR_LEN;
endpackage

// File: rtl/eth_byte_fifo.sv
// eth_byte_fifo: byte FIFO on an inferred dual-port RAM with a registered read port
// Ports: clk, reset_i (sync, active high); wr_en/wr_data push; rd_en pops;
//        rd_data shows the head byte; count/full/empty report occupancy.
module eth_byte_fifo #(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp, rp_next;
    logic          wr, rd;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign wr      = wr_en & ~full;
    assign rd      = rd_en & ~empty;
    assign rp_next = rd ? rp + AW'(1) : rp;
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= wr_data;
    end
    // The read register follows the next read address, so a popped byte is
    // replaced by its successor on the same edge; it refreshes every cycle.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            rd_data <= 8'h00;
        end else begin
            wp      <= wr ? wp + AW'(1) : wp;
            rp      <= rp_next;
            count   <= count + CW'(wr) - CW'(rd);
            rd_data <= mem[rp_next];
        end
    end
endmodule

// File: rtl/eth_udp_packetizer.sv
// eth_udp_packetizer: buffers capture bytes and issues fixed-length or padded short UDP payloads
// Ports: clk, reset_i (sync, active high); in_data_i/in_valid_i/in_ready_o byte input;
//        flush_i sends pending bytes; usr_start_o/usr_data_len_o/usr_datard_i/usr_data_o
//        transmitter handshake; pkt_count_o frames issued; overflow_o sticky drop flag.
module eth_udp_packetizer
    import eth_pkt_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int PKT_LEN = 1024,
    parameter int MIN_LEN = MIN_UDP_LEN,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        usr_start_o,
    output logic [15:0] usr_data_len_o,
    input  logic        usr_datard_i,
    output logic [7:0]  usr_data_o,
    output logic [15:0] pkt_count_o,
    output logic        overflow_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic [CW-1:0] count;
    logic [15:0]   cnt16, len, real_len, idx;
    logic [TW-1:0] timer;
    logic [7:0]    fifo_data;
    logic          full, empty, wr, rd, has_real;
    assign cnt16          = 16'(count);
    assign in_ready_o     = ~reset_i & ~full;
    assign wr             = in_valid_i & in_ready_o;
    assign has_real       = idx < real_len;
    // Bytes past the buffered part of a short frame are zero pad and never popped.
    assign rd             = usr_datard_i & (state != IDLE) & has_real & ~empty;
    assign usr_data_o     = has_real ? fifo_data : 8'h00;
    assign usr_data_len_o = state == IDLE ? 16'(PKT_LEN) : len;
    eth_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .wr_en   (wr),
        .wr_data (in_data_i),
        .rd_en   (rd),
        .rd_data (fifo_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= IDLE;
            usr_start_o <= 1'b0;
            len         <= '0;
            real_len    <= '0;
            idx         <= '0;
            timer       <= '0;
            pkt_count_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            overflow_o <= overflow_o | (in_valid_i & ~in_ready_o);
            timer      <= (wr || count == '0 || state != IDLE) ? '0 :
                          timer == TW'(TIMEOUT) ? timer : timer + TW'(1);
            if (state == IDLE) begin
                idx <= '0;
                if (cnt16 >= 16'(PKT_LEN)) begin
                    state       <= START;
                    usr_start_o <= 1'b1;
                    len         <= 16'(PKT_LEN);
                    real_len    <= 16'(PKT_LEN);
                end else if (count != '0 && (timer == TW'(TIMEOUT) || flush_i)) begin
                    state       <= START;
                    usr_start_o <= 1'b1;
                    len         <= cnt16 < 16'(MIN_LEN) ? 16'(MIN_LEN) : cnt16;
                    real_len    <= cnt16;
                end
            end else if (usr_datard_i) begin
                usr_start_o <= 1'b0;
                idx         <= idx + 16'd1;
                if (idx + 16'd1 == len) begin
                    state       <= IDLE;
                    pkt_count_o <= pkt_count_o + 16'd1;
                end else begin
                    state <= SEND;
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_udp_packetizer.sv
// tb_eth_udp_packetizer: directed self-checking bench for eth_udp_packetizer
module tb_eth_udp_packetizer;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic        usr_start_o;
    logic [15:0] usr_data_len_o;
    logic        usr_datard_i = 1'b0;
    logic [7:0]  usr_data_o;
    logic [15:0] pkt_count_o;
    logic        overflow_o;
    logic [7:0]  rx [128];
    int          n_cmp = 0;
    int          n_err = 0;

    eth_udp_packetizer #(.DEPTH(64), .PKT_LEN(32), .MIN_LEN(18), .TIMEOUT(100)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .in_data_i      (in_data_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .flush_i        (flush_i),
        .usr_start_o    (usr_start_o),
        .usr_data_len_o (usr_data_len_o),
        .usr_datard_i   (usr_datard_i),
        .usr_data_o     (usr_data_o),
        .pkt_count_o    (pkt_count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i  = first + 8'(i);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic read_frame(input int base, input int n, output bit ok,
                              output logic [15:0] len_seen, output logic start_after);
        int cyc = 0;
        while (!usr_start_o && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        ok = usr_start_o;
        len_seen = usr_data_len_o;
        start_after = 1'bx;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                rx[base+i] = usr_data_o;
                usr_datard_i = 1'b1;
                @(negedge clk);
                usr_datard_i = 1'b0;
                if (i == 0) start_after = usr_start_o;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle_watch(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (usr_start_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready_o); end
        n_cmp++; if (usr_start_o !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", usr_start_o); end
        n_cmp++; if (usr_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", usr_data_o); end
        n_cmp++; if (pkt_count_o !== 16'd0) begin n_err++; $display("FAIL reset_pkt: got %0d want 0", pkt_count_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        reset_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", in_ready_o); end
        n_cmp++; if (usr_data_len_o !== 16'd32) begin n_err++; $display("FAIL idle_len: got %0d want 32", usr_data_len_o); end
    endtask

    task automatic test_full_frame;
        bit ok;
        logic [15:0] len;
        logic sa;
        write_bytes(8'h00, 32);
        read_frame(0, 32, ok, len, sa);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL full_start: got %b want 1", ok); end
        n_cmp++; if (len !== 16'd32) begin n_err++; $display("FAIL full_len: got %0d want 32", len); end
        n_cmp++; if (sa !== 1'b0) begin n_err++; $display("FAIL full_start_drop: got %b want 0", sa); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (rx[i] !== 8'(i)) begin n_err++; $display("FAIL full_byte%0d: got %h want %h", i, rx[i], 8'(i)); end
        end
        n_cmp++; if (pkt_count_o !== 16'd1) begin n_err++; $display("FAIL full_pkt: got %0d want 1", pkt_count_o); end
    endtask

    task automatic test_timeout;
        bit ok;
        logic [15:0] len;
        logic sa;
        int cyc = 0;
        write_bytes(8'hA0, 5);
        while (!usr_start_o && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 101) begin n_err++; $display("FAIL timeout_delay: got %0d want 101", cyc); end
        read_frame(0, 18, ok, len, sa);
        n_cmp++; if (len !== 16'd18) begin n_err++; $display("FAIL timeout_len: got %0d want 18", len); end
        for (int i = 0; i < 18; i++) begin
            logic [7:0] e;
            e = i < 5 ? 8'hA0 + 8'(i) : 8'h00;
            n_cmp++; if (rx[i] !== e) begin n_err++; $display("FAIL timeout_byte%0d: got %h want %h", i, rx[i], e); end
        end
        n_cmp++; if (pkt_count_o !== 16'd2) begin n_err++; $display("FAIL timeout_pkt: got %0d want 2", pkt_count_o); end
    endtask

    task automatic test_flush;
        bit ok, seen;
        logic [15:0] len;
        logic sa;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        idle_watch(20, seen);
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_empty: got start %b want 0", seen); end
        write_bytes(8'h40, 20);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        read_frame(0, 20, ok, len, sa);
        n_cmp++; if (len !== 16'd20) begin n_err++; $display("FAIL flush_len: got %0d want 20", len); end
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (rx[i] !== 8'h40 + 8'(i)) begin n_err++; $display("FAIL flush_byte%0d: got %h want %h", i, rx[i], 8'h40 + 8'(i)); end
        end
        n_cmp++; if (pkt_count_o !== 16'd3) begin n_err++; $display("FAIL flush_pkt: got %0d want 3", pkt_count_o); end
        idle_watch(150, seen);
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_drained: got start %b want 0", seen); end
    endtask

    task automatic test_overflow;
        bit ok1, ok2, seen;
        logic [15:0] l1, l2;
        logic sa;
        write_bytes(8'h00, 70);
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %b want 0", in_ready_o); end
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        read_frame(0, 32, ok1, l1, sa);
        read_frame(32, 32, ok2, l2, sa);
        n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_err++; $display("FAIL ovf_frames: got %b want 11", {ok1, ok2}); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++; if (rx[i] !== 8'(i)) begin n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx[i], 8'(i)); end
        end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL ovf_ready_back: got %b want 1", in_ready_o); end
        n_cmp++; if (pkt_count_o !== 16'd5) begin n_err++; $display("FAIL ovf_pkt: got %0d want 5", pkt_count_o); end
        idle_watch(150, seen);
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ovf_dropped: got start %b want 0", seen); end
        n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2;
        logic [15:0] l1, l2;
        logic s1, s2;
        fork
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                in_valid_i = 1'b1;
                in_data_i  = 8'h80 + 8'(i);
                @(negedge clk);
                in_valid_i = 1'b0;
            end
            begin
                read_frame(0, 32, ok1, l1, s1);
                read_frame(32, 32, ok2, l2, s2);
            end
        join
        n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_err++; $display("FAIL b2b_frames: got %b want 11", {ok1, ok2}); end
        n_cmp++; if ({l1, l2} !== {16'd32, 16'd32}) begin n_err++; $display("FAIL b2b_len: got %0d/%0d want 32/32", l1, l2); end
        for (int i = 0; i < 64; i++) begin
            n_cmp++; if (rx[i] !== 8'h80 + 8'(i)) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx[i], 8'h80 + 8'(i)); end
        end
        n_cmp++; if (pkt_count_o !== 16'd7) begin n_err++; $display("FAIL b2b_pkt: got %0d want 7", pkt_count_o); end
    endtask

    task automatic test_reset_mid;
        bit ok, seen;
        logic [15:0] len;
        logic sa;
        write_bytes(8'h10, 32);
        read_frame(0, 5, ok, len, sa);
        reset_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (usr_start_o !== 1'b0) begin n_err++; $display("FAIL rmid_start: got %b want 0", usr_start_o); end
        n_cmp++; if (pkt_count_o !== 16'd0) begin n_err++; $display("FAIL rmid_pkt: got %0d want 0", pkt_count_o); end
        n_cmp++; if (usr_data_o !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h want 00", usr_data_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rmid_ovf: got %b want 0", overflow_o); end
        reset_i = 1'b0;
        idle_watch(150, seen);
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_discard: got start %b want 0", seen); end
        write_bytes(8'h60, 32);
        read_frame(0, 32, ok, len, sa);
        n_cmp++; if (len !== 16'd32) begin n_err++; $display("FAIL rmid_len: got %0d want 32", len); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (rx[i] !== 8'h60 + 8'(i)) begin n_err++; $display("FAIL rmid_byte%0d: got %h want %h", i, rx[i], 8'h60 + 8'(i)); end
        end
        n_cmp++; if (pkt_count_o !== 16'd1) begin n_err++; $display("FAIL rmid_pkt_after: got %0d want 1", pkt_count_o); end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_timeout;
        test_flush;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
